spart_bus_responder: RTL and testbench

- Memory-mapped bus responder for the SPART serial port; the target end of the transactions the bootloader and CPU initiate on the shared write/read/addr/data/ack bus.
- Decodes three byte-wide registers starting at BASE_ADDR, which is the address the boot flow uses.
- Forwards TX writes to the UART serializer through a valid/ready handshake.
- Buffers bytes from the UART deserializer in a small RX FIFO and returns them to bus reads, stalling the initiator through ack_o until data or TX capacity exists.

---
 rtl/spart_pkg.sv | 35 +++
 rtl/spart_rx_fifo.sv | 71 +++++++
 rtl/spart_bus_responder.sv | 146 ++++++++++++++
 tb/tb_spart_bus_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// SPART bus responder shared types and register map.
// Imported by the responder top and its RX FIFO.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TX_SEND,
    RX_WAIT,
    ACK
  } spart_resp_state_t;

  localparam logic [31:0] SPART_BASE     = 32'h4000_001C;
  localparam logic [31:0] SPART_TX_OFS   = 32'd0;
  localparam logic [31:0] SPART_RX_OFS   = 32'd1;
  localparam logic [31:0] SPART_STAT_OFS = 32'd2;
  localparam logic [31:0] SPART_NUM_REGS = 32'd3;

  localparam int STAT_RXNE_BIT  = 0;
  localparam int STAT_TXRDY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;

  function automatic logic [31:0] spart_status(
    input logic ovf,
    input logic txr,
    input logic rxne
  );
    logic [31:0] s;
    s = '0;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_TXRDY_BIT] = txr;
    s[STAT_RXNE_BIT]  = rxne;
    return s;
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Byte FIFO between the UART deserializer and bus reads.
// A push into a full FIFO is dropped unless a pop frees a slot.
module spart_rx_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign dout    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/spart_bus_responder.sv
// SPART target on the write/read/addr/data/ack bus.
// TX bytes go out via valid/ready; RX bytes come back through a FIFO.
module spart_bus_responder
  import spart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SPART_BASE,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_i,
  input  logic        read_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_overflow
);

  spart_resp_state_t state_q, state_d;

  logic [31:0] data_q, data_d;
  logic [7:0]  txd_q, txd_d;
  logic        ovf_q, ovf_d;
  logic [31:0] ofs;
  logic        hit;
  logic        is_tx;
  logic        is_rx;
  logic        is_stat;
  logic        pop;
  logic        ovf_clr;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_drop;
  logic        unused_hi;

  assign unused_hi = ^data_i[31:8];

  // Offset compare covers BASE..BASE+2 without a second comparator.
  assign ofs     = addr_i - BASE_ADDR;
  assign hit     = (write_i | read_i) & (ofs < SPART_NUM_REGS);
  assign is_tx   = (ofs == SPART_TX_OFS);
  assign is_rx   = (ofs == SPART_RX_OFS);
  assign is_stat = (ofs == SPART_STAT_OFS);

  spart_rx_fifo #(
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_valid),
    .din  (rx_data),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full),
    .drop (fifo_drop)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    ovf_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit && write_i) begin
          if (is_tx) begin
            txd_d   = data_i[7:0];
            state_d = TX_SEND;
          end else begin
            state_d = ACK;
          end
        end else if (hit) begin
          unique case (1'b1)
            is_tx: begin
              data_d  = '0;
              state_d = ACK;
            end
            is_rx: begin
              if (!fifo_empty) begin
                pop     = 1'b1;
                data_d  = {24'h0, fifo_dout};
                state_d = ACK;
              end else begin
                state_d = RX_WAIT;
              end
            end
            is_stat: begin
              data_d  = spart_status(ovf_q, tx_ready,
                                     ~fifo_empty);
              ovf_clr = 1'b1;
              state_d = ACK;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      TX_SEND: begin
        if (tx_ready) begin
          state_d = ACK;
        end
      end
      RX_WAIT: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = {24'h0, fifo_dout};
          state_d = ACK;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as a status read keeps the flag set.
  assign ovf_d = (ovf_q & ~ovf_clr) | fifo_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      txd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ack_o       = (state_q == ACK);
  assign tx_valid    = (state_q == TX_SEND);
  assign tx_data     = txd_q;
  assign data_o      = data_q;
  assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_spart_bus_responder.sv
// Scoreboard bench for spart_bus_responder.
// Bus/TX expectations are queued at issue and popped on ack/handshake.
module tb_spart_bus_responder;

  localparam logic [31:0] BASE = 32'h4000_001C;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        write_i;
  logic        read_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_overflow;

  typedef struct {
    bit          rd;
    logic [31:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] txq[$];
  logic [7:0] model[$];
  logic       ovf_m;
  int         n_chk;
  int         n_pass;

  spart_bus_responder #(
    .BASE_ADDR(BASE),
    .RX_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .write_i    (write_i),
    .read_i     (read_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_overflow(rx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ack_o) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.rd) chk("ack_data", data_o, e.d);
      end
    end
    if (!rst && tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        chk("spurious_tx", {24'h0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] b;
        b = txq.pop_front();
        chk("tx_byte", {24'h0, tx_data}, {24'h0, b});
      end
    end
  end

  task automatic bus(input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] ed,
                     input bit hit, input bit both, output int lat);
    exp_t e;
    if (hit) begin
      e.rd = !wr;
      e.d  = ed;
      sb.push_back(e);
    end
    write_i = wr;
    read_i  = !wr | both;
    addr_i  = a;
    data_i  = d;
    lat     = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_o) begin
        lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    write_i = 1'b0;
    read_i  = 1'b0;
  endtask

  task automatic wr_tx(input logic [7:0] b);
    int lat;
    txq.push_back(b);
    bus(1'b1, BASE, {24'hA5A5A5, b}, 32'h0, 1'b1, 1'b0, lat);
    chk("tx_lat", lat, 2);
  endtask

  task automatic rd_rx();
    int lat;
    logic [7:0] b;
    b = model.pop_front();
    bus(1'b0, BASE + 1, 32'h0, {24'h0, b}, 1'b1, 1'b0, lat);
    chk("rx_lat", lat, 1);
  endtask

  task automatic rd_stat();
    int lat;
    logic [31:0] e;
    e = {29'b0, ovf_m, tx_ready, (model.size() != 0)};
    ovf_m = 1'b0;
    bus(1'b0, BASE + 2, 32'h0, e, 1'b1, 1'b0, lat);
    chk("stat_lat", lat, 1);
  endtask

  task automatic inject(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (model.size() < DEPTH) model.push_back(b);
    else ovf_m = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    write_i  = 1'b0;
    read_i   = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model.delete();
    ovf_m = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int hold_bad;
    logic [7:0] b;
    logic [7:0] stream [12];
    n_chk = 0;
    n_pass = 0;
    ovf_m = 1'b0;
    rst = 1'b1;
    write_i = 1'b0;
    read_i = 1'b0;
    addr_i = '0;
    data_i = '0;
    tx_ready = 1'b1;
    rx_data = '0;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'b0, ack_o}, 0);
    chk("rst_data", data_o, 0);
    chk("rst_txv", {31'b0, tx_valid}, 0);
    chk("rst_txd", {24'b0, tx_data}, 0);
    chk("rst_ovf", {31'b0, rx_overflow}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_stat();

    wr_tx(8'h42);

    tx_ready = 1'b0;
    txq.push_back(8'h49);
    hold_bad = 0;
    fork
      bus(1'b1, BASE, 32'hFFFF_FF49, 32'h0, 1'b1, 1'b0, lat);
      begin
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (!(tx_valid === 1'b1 && tx_data === 8'h49))
            hold_bad++;
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
      end
    join
    chk("bp_hold", hold_bad, 0);
    chk("bp_lat", lat, 12);

    fork
      bus(1'b0, BASE + 1, 32'h0, 32'h5, 1'b1, 1'b0, lat);
      begin
        repeat (7) @(posedge clk);
        #1;
        rx_data = 8'h05;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
      end
    join
    chk("blk_lat", lat, 9);
    rd_stat();

    stream = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00};
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 4; k++) inject(stream[g * 4 + k]);
      for (int k = 0; k < 4; k++) rd_rx();
      wr_tx(g[0] ? 8'h41 : 8'h49);
    end
    bus(1'b0, BASE, 32'h0, 32'h0, 1'b1, 1'b0, lat);
    chk("rd_tx_lat", lat, 1);

    txq.push_back(8'h57);
    bus(1'b1, BASE, 32'h57, 32'h0, 1'b1, 1'b1, lat);
    chk("wwins_lat", lat, 2);

    for (int k = 0; k < 5; k++) inject(8'hA0 + 8'(k));
    chk("ovf_flag", {31'b0, rx_overflow}, 1);
    tx_ready = 1'b0;
    rd_stat();
    tx_ready = 1'b1;
    rd_stat();
    for (int k = 0; k < 4; k++) rd_rx();
    bus(1'b1, BASE + 2, 32'hFF, 32'h0, 1'b1, 1'b0, lat);
    chk("ign_lat", lat, 1);
    chk("data_hold", data_o, 32'hA3);
    rd_stat();

    for (int k = 0; k < 4; k++) inject(8'hB0 + 8'(k));
    b = model.pop_front();
    model.push_back(8'hB4);
    fork
      bus(1'b0, BASE + 1, 32'h0, {24'h0, b}, 1'b1, 1'b0, lat);
      begin
        rx_data = 8'hB4;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
      end
    join
    chk("pp_lat", lat, 1);
    chk("pp_noovf", {31'b0, rx_overflow}, 0);
    for (int k = 0; k < 4; k++) rd_rx();

    bus(1'b0, 32'h4000_0020, 32'h0, 32'h0, 1'b0, 1'b0, lat);
    chk("miss_rd", lat, 32'hFFFF_FFFF);
    bus(1'b1, 32'h4000_0020, 32'h33, 32'h0, 1'b0, 1'b0, lat);
    chk("miss_wr", lat, 32'hFFFF_FFFF);
    rd_stat();

    inject(8'h11);
    inject(8'h22);
    do_reset();
    rd_stat();
    read_i = 1'b1;
    addr_i = BASE + 1;
    repeat (4) @(negedge clk);
    chk("wait_noack", {31'b0, ack_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    read_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ack", {31'b0, ack_o}, 0);
    chk("post_rst_ovf", {31'b0, rx_overflow}, 0);
    @(posedge clk);
    #1;
    rd_stat();

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("txq_empty", txq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
